// File: rtl/planificador_mantenimiento_if.sv
// Bundle of request/grant and status signals between the units and the
// maintenance scheduler. The scheduler is the slave and the requesting side
// is the master.
interface planificador_mantenimiento_if #(
    parameter int N   = 4,
    parameter int IDW = 3
);
    logic [N-1:0]   solicitud;
    logic [N-1:0]   fin;
    logic           borrar_error;
    logic [N-1:0]   concesion;
    logic           ocupado;
    logic [IDW-1:0] id_activo;
    logic [7:0]     num_servicios;
    logic           error_timeout;
    logic [IDW-1:0] id_error;
    logic [N-1:0]   mascara;

    modport master (
        output solicitud, fin, borrar_error,
        input  concesion, ocupado, id_activo, num_servicios,
               error_timeout, id_error, mascara
    );

    modport slave (
        input  solicitud, fin, borrar_error,
        output concesion, ocupado, id_activo, num_servicios,
               error_timeout, id_error, mascara
    );
endinterface

// File: rtl/planificador_mantenimiento.sv
// Round-robin scheduler for a single shared maintenance station. One unit is
// granted at a time, each service is timed against a cycle budget, overrunning
// units are masked out for good, and completed services are counted.
module planificador_mantenimiento #(
    parameter int N          = 4,
    parameter int MAX_CICLOS = 200,
    parameter int IDW        = 3
) (
    input logic                        clk,
    input logic                        reset,
    planificador_mantenimiento_if.slave bus
);

    typedef enum logic [1:0] {
        ESPERA = 2'b00,
        ACTIVO = 2'b01,
        ERROR  = 2'b10
    } estado_t;

    estado_t        estado_q;
    logic [N-1:0]   concesion_q;
    logic [IDW-1:0] id_activo_q;
    logic [IDW-1:0] puntero_q;
    logic [IDW-1:0] id_error_q;
    logic [N-1:0]   mascara_q;
    logic [7:0]     cuenta_q;
    logic [7:0]     ciclos_q;

    logic [N-1:0]   elegible;
    logic [2*N-1:0] doble;
    logic [N-1:0]   rotado;
    logic           hay_ganador_d;
    logic [IDW-1:0] ganador_d;
    logic [IDW:0]   suma;
    logic           fin_activo;
    logic [IDW-1:0] siguiente;

    // Pick the first eligible unit at or after the pointer, wrapping around,
    // by rotating the eligible vector so the pointer lands on bit 0.
    always_comb begin
        elegible      = bus.solicitud & ~mascara_q;
        doble         = {elegible, elegible} >> puntero_q;
        rotado        = doble[N-1:0];
        hay_ganador_d = 1'b0;
        ganador_d     = '0;
        suma          = '0;
        for (int i = 0; i < N; i++) begin
            if (!hay_ganador_d && rotado[i]) begin
                hay_ganador_d = 1'b1;
                suma          = {1'b0, puntero_q} + (IDW+1)'(i);
                if (suma >= (IDW+1)'(N)) begin
                    suma = suma - (IDW+1)'(N);
                end
                ganador_d = suma[IDW-1:0];
            end
        end
    end

    // Completion is only honoured from the unit that holds the grant, and the
    // next search starts just after that unit.
    always_comb begin
        fin_activo = |(bus.fin & concesion_q);
        siguiente  = (id_activo_q == IDW'(N-1)) ? '0 : id_activo_q + 1'b1;
    end

    // Scheduler state machine: arbitrate in ESPERA, time the service in
    // ACTIVO, and park in ERROR after an overrun until it is cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q    <= ESPERA;
            concesion_q <= '0;
            id_activo_q <= '0;
            puntero_q   <= '0;
            id_error_q  <= '0;
            mascara_q   <= '0;
            cuenta_q    <= '0;
            ciclos_q    <= '0;
        end else begin
            case (estado_q)
                ESPERA: begin
                    if (hay_ganador_d) begin
                        estado_q    <= ACTIVO;
                        concesion_q <= N'(1) << ganador_d;
                        id_activo_q <= ganador_d;
                        ciclos_q    <= '0;
                    end
                end
                ACTIVO: begin
                    ciclos_q <= ciclos_q + 8'd1;
                    if (fin_activo) begin
                        cuenta_q    <= (cuenta_q >= 8'hFE) ? 8'hFE : cuenta_q + 8'd1;
                        puntero_q   <= siguiente;
                        concesion_q <= '0;
                        estado_q    <= ESPERA;
                    end else if (ciclos_q == 8'(MAX_CICLOS - 1)) begin
                        estado_q    <= ERROR;
                        id_error_q  <= id_activo_q;
                        mascara_q   <= mascara_q | concesion_q;
                        concesion_q <= '0;
                        puntero_q   <= siguiente;
                    end
                end
                ERROR: begin
                    if (bus.borrar_error) begin
                        estado_q <= ESPERA;
                    end
                end
                default: begin
                    estado_q    <= ESPERA;
                    concesion_q <= '0;
                end
            endcase
        end
    end

    // While in ERROR the count is hidden behind 8'hFF but kept internally.
    always_comb begin
        bus.concesion     = concesion_q;
        bus.ocupado       = |concesion_q;
        bus.id_activo     = id_activo_q;
        bus.error_timeout = (estado_q == ERROR);
        bus.num_servicios = (estado_q == ERROR) ? 8'hFF : cuenta_q;
        bus.id_error      = id_error_q;
        bus.mascara       = mascara_q;
    end

endmodule

// File: tb/tb_planificador_mantenimiento.sv
// Directed testbench for the maintenance scheduler with N=4, MAX_CICLOS=200.
module tb_planificador_mantenimiento;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    int orden1 [5] = '{1, 2, 3, 0, 1};
    int orden2 [4] = '{3, 0, 1, 3};

    planificador_mantenimiento_if #(.N(4), .IDW(3)) bus ();

    planificador_mantenimiento #(.N(4), .MAX_CICLOS(200), .IDW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive the requester-side inputs.
    task automatic applyStimulus(input logic [3:0] sol, input logic [3:0] f, input logic borrar);
        bus.solicitud    = sol;
        bus.fin          = f;
        bus.borrar_error = borrar;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Linear sequence of directed steps.
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick(2);

        $display("[TB] reset values");
        checkOutput("rst_concesion", 32'(bus.concesion), 32'h0);
        checkOutput("rst_ocupado", 32'(bus.ocupado), 32'h0);
        checkOutput("rst_num", 32'(bus.num_servicios), 32'h0);
        checkOutput("rst_error", 32'(bus.error_timeout), 32'h0);
        checkOutput("rst_mascara", 32'(bus.mascara), 32'h0);
        checkOutput("rst_id_error", 32'(bus.id_error), 32'h0);
        reset = 1'b0;

        $display("[TB] single service for unit 0");
        applyStimulus(4'b0001, 4'b0000, 1'b0);
        tick(1);
        checkOutput("t1_grant", 32'(bus.concesion), 32'h1);
        checkOutput("t1_ocupado", 32'(bus.ocupado), 32'h1);
        checkOutput("t1_id", 32'(bus.id_activo), 32'h0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick(9);
        checkOutput("t1_hold", 32'(bus.concesion), 32'h1);
        applyStimulus(4'b0000, 4'b0001, 1'b0);
        tick(1);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("t1_release", 32'(bus.concesion), 32'h0);
        checkOutput("t1_num", 32'(bus.num_servicios), 32'h1);

        $display("[TB] round robin with all units requesting");
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        tick(1);
        for (int k = 0; k < 5; k++) begin
            checkOutput("t2_grant", 32'(bus.concesion), 32'(1 << orden1[k]));
            tick(4);
            applyStimulus(4'b1111, 4'(1 << orden1[k]), 1'b0);
            tick(1);
            applyStimulus(4'b1111, 4'b0000, 1'b0);
            checkOutput("t2_idle", 32'(bus.concesion), 32'h0);
            tick(1);
        end
        checkOutput("t2_num", 32'(bus.num_servicios), 32'h6);

        $display("[TB] timeout on unit 2");
        checkOutput("t3_grant", 32'(bus.concesion), 32'h4);
        checkOutput("t3_id", 32'(bus.id_activo), 32'h2);
        tick(199);
        checkOutput("t3_not_yet", 32'(bus.error_timeout), 32'h0);
        checkOutput("t3_still_granted", 32'(bus.concesion), 32'h4);
        tick(1);
        checkOutput("t3_error", 32'(bus.error_timeout), 32'h1);
        checkOutput("t3_id_error", 32'(bus.id_error), 32'h2);
        checkOutput("t3_mascara", 32'(bus.mascara), 32'h4);
        checkOutput("t3_num_ff", 32'(bus.num_servicios), 32'hFF);
        checkOutput("t3_no_grant", 32'(bus.concesion), 32'h0);
        checkOutput("t3_not_busy", 32'(bus.ocupado), 32'h0);
        tick(3);
        checkOutput("t3_error_held", 32'(bus.error_timeout), 32'h1);
        applyStimulus(4'b1111, 4'b0000, 1'b1);
        tick(1);
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        checkOutput("t3_cleared", 32'(bus.error_timeout), 32'h0);
        checkOutput("t3_num_restored", 32'(bus.num_servicios), 32'h6);
        checkOutput("t3_clear_idle", 32'(bus.concesion), 32'h0);
        tick(1);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t3_rr_grant", 32'(bus.concesion), 32'(1 << orden2[k]));
            tick(4);
            applyStimulus(4'b1111, 4'(1 << orden2[k]), 1'b0);
            tick(1);
            applyStimulus(4'b1111, 4'b0000, 1'b0);
            checkOutput("t3_rr_idle", 32'(bus.concesion), 32'h0);
            tick(1);
        end
        checkOutput("t3_num_after", 32'(bus.num_servicios), 32'hA);

        $display("[TB] completion on the last budget cycle");
        checkOutput("t4_grant0", 32'(bus.concesion), 32'h1);
        tick(199);
        applyStimulus(4'b1111, 4'b0001, 1'b0);
        tick(1);
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        checkOutput("t4_no_error", 32'(bus.error_timeout), 32'h0);
        checkOutput("t4_release", 32'(bus.concesion), 32'h0);
        checkOutput("t4_num", 32'(bus.num_servicios), 32'hB);
        tick(1);
        checkOutput("t4_grant1", 32'(bus.concesion), 32'h2);
        applyStimulus(4'b1111, 4'b1000, 1'b0);
        tick(1);
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        checkOutput("t4_foreign_fin", 32'(bus.concesion), 32'h2);
        checkOutput("t4_foreign_num", 32'(bus.num_servicios), 32'hB);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick(2);
        checkOutput("t4_drop_request", 32'(bus.concesion), 32'h2);
        applyStimulus(4'b0000, 4'b0010, 1'b0);
        tick(1);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("t4_num_done", 32'(bus.num_servicios), 32'hC);
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        tick(1);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("t4_stray_clear", 32'(bus.error_timeout), 32'h0);

        $display("[TB] saturation of the service count");
        for (int k = 0; k < 242; k++) begin
            applyStimulus(4'b1000, 4'b0000, 1'b0);
            tick(1);
            applyStimulus(4'b1000, 4'b1000, 1'b0);
            tick(1);
            applyStimulus(4'b1000, 4'b0000, 1'b0);
        end
        checkOutput("t5_num_fe", 32'(bus.num_servicios), 32'hFE);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            applyStimulus(4'b1000, 4'b1000, 1'b0);
            tick(1);
            applyStimulus(4'b1000, 4'b0000, 1'b0);
        end
        checkOutput("t5_num_sat", 32'(bus.num_servicios), 32'hFE);

        $display("[TB] asynchronous reset mid service");
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        tick(1);
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        tick(1);
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        tick(1);
        checkOutput("t6_grant", 32'(bus.concesion), 32'h2);
        checkOutput("t6_busy", 32'(bus.ocupado), 32'h1);
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_grant", 32'(bus.concesion), 32'h0);
        checkOutput("t6_async_busy", 32'(bus.ocupado), 32'h0);
        checkOutput("t6_async_num", 32'(bus.num_servicios), 32'h0);
        checkOutput("t6_async_mascara", 32'(bus.mascara), 32'h0);
        tick(1);
        reset = 1'b0;
        applyStimulus(4'b1111, 4'b0000, 1'b0);
        tick(1);
        checkOutput("t6_ptr_zero", 32'(bus.concesion), 32'h1);
        checkOutput("t6_num_after", 32'(bus.num_servicios), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
